// File: rtl/ahb2_pkg.sv
// ahb2_pkg: AMBA2 AHB encodings shared by AHB2 blocks.
//   htrans_e - transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_e - burst type (SINGLE..INCR16)
//   hresp_e  - slave response (OKAY/ERROR/RETRY/SPLIT)
//   burst_len() - beat count of a fixed-length burst, 0 for SINGLE/INCR
package ahb2_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   function automatic logic [4:0] burst_len(input logic [2:0] hburst);
      logic [4:0] len;
      len = 5'd0;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
         default:                      len = 5'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahb2_arbiter_if.sv
// ahb2_arbiter_if: arbitration signals between N AHB2 masters and the arbiter.
//   hbusreq/hlock    - per-master request and lock request
//   htrans/hburst    - muxed address-phase control of the current owner
//   hready/hresp     - muxed slave ready and response
//   hgrant           - one-hot grant
//   hmaster/hmastlock - current address-bus owner and its lock state
// Modports: slave (arbiter side), master (requesting side).
interface ahb2_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 4
);
   localparam int unsigned MIDX_W = $clog2(NUM_MASTERS);

   logic [NUM_MASTERS-1:0] hbusreq;
   logic [NUM_MASTERS-1:0] hlock;
   logic [1:0]             htrans;
   logic [2:0]             hburst;
   logic                   hready;
   logic [1:0]             hresp;
   logic [NUM_MASTERS-1:0] hgrant;
   logic [MIDX_W-1:0]      hmaster;
   logic                   hmastlock;

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready, hresp,
      output hgrant, hmaster, hmastlock
   );

   modport master (
      output hbusreq, hlock, htrans, hburst, hready, hresp,
      input  hgrant, hmaster, hmastlock
   );
endinterface

// File: rtl/ahb2_rr_picker.sv
// ahb2_rr_picker: rotating priority encoder.
//   req   - request vector
//   ptr   - last winner; scanning starts at ptr+1 and wraps
//   valid - some request is set
//   idx   - index of the first request found
// With ptr = NUM_MASTERS-1 this is a plain lowest-index priority encoder.
module ahb2_rr_picker #(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned MIDX_W      = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [MIDX_W-1:0]      ptr,
   output logic                   valid,
   output logic [MIDX_W-1:0]      idx
);
   int m;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      m     = 0;
      // Scan from the far end so the nearest request after ptr is written last.
      for (int k = int'(NUM_MASTERS); k >= 1; k--) begin
         m = (int'(ptr) + k) % int'(NUM_MASTERS);
         if (req[m]) begin
            valid = 1'b1;
            idx   = m[MIDX_W-1:0];
         end
      end
   end
endmodule

// File: rtl/ahb2_arbiter.sv
// ahb2_arbiter: AHB2 bus arbiter for NUM_MASTERS masters.
//   hclk     - bus clock
//   hreset_n - asynchronous active-low reset
//   bus      - ahb2_arbiter_if.slave: requests, muxed transfer control,
//              hready/hresp in; hgrant, hmaster, hmastlock out (all registered)
// Fixed-length bursts and locked sequences keep the grant; otherwise the
// grant moves on every accepted transfer. Idle bus parks on DEFAULT_MASTER.
module ahb2_arbiter
   import ahb2_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 4,
   parameter bit          RR_MODE        = 1'b1,
   parameter int unsigned DEFAULT_MASTER = 0
) (
   input logic          hclk,
   input logic          hreset_n,
   ahb2_arbiter_if.slave bus
);
   localparam int unsigned          MIDX_W    = $clog2(NUM_MASTERS);
   localparam logic [MIDX_W-1:0]    DEF_IDX   = MIDX_W'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;

   logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
   logic [MIDX_W-1:0]      hmaster_q;
   logic                   hmastlock_q;
   logic [MIDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [4:0]             beats_left_q, beats_left_d;
   logic [MIDX_W-1:0]      gidx, pick_ptr, pick_idx, winner;
   logic                   pick_valid, hold, rearb;

   always_comb begin
      gidx = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (hgrant_q[i]) gidx = MIDX_W'(i);
      end
   end

   // Any non-OKAY response terminates the burst, even while hready is low.
   always_comb begin
      beats_left_d = beats_left_q;
      if (bus.hresp != HRESP_OKAY) begin
         beats_left_d = '0;
      end else if (bus.hready) begin
         unique case (bus.htrans)
            HTRANS_NONSEQ: begin
               if (burst_len(bus.hburst) != 5'd0) beats_left_d = burst_len(bus.hburst) - 5'd1;
               else                               beats_left_d = '0;
            end
            HTRANS_SEQ:  if (beats_left_q != '0) beats_left_d = beats_left_q - 5'd1;
            HTRANS_IDLE: beats_left_d = '0;
            default:     beats_left_d = beats_left_q;
         endcase
      end
   end

   assign pick_ptr = RR_MODE ? rr_ptr_q : MIDX_W'(NUM_MASTERS - 1);

   ahb2_rr_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .MIDX_W      (MIDX_W)
   ) u_picker (
      .req   (bus.hbusreq),
      .ptr   (pick_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign winner = pick_valid ? pick_idx : DEF_IDX;
   assign hold   = (beats_left_d != '0) || (bus.hlock[gidx] && bus.hbusreq[gidx]);
   assign rearb  = bus.hready && !hold;

   always_comb begin
      hgrant_d = hgrant_q;
      rr_ptr_d = rr_ptr_q;
      if (rearb) begin
         hgrant_d         = '0;
         hgrant_d[winner] = 1'b1;
         if (pick_valid) rr_ptr_d = winner;
      end
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         hgrant_q     <= GRANT_RST;
         hmaster_q    <= DEF_IDX;
         hmastlock_q  <= 1'b0;
         rr_ptr_q     <= DEF_IDX;
         beats_left_q <= '0;
      end else begin
         hgrant_q     <= hgrant_d;
         rr_ptr_q     <= rr_ptr_d;
         beats_left_q <= beats_left_d;
         // Ownership follows the grant one accepted transfer later.
         if (bus.hready) begin
            hmaster_q   <= gidx;
            hmastlock_q <= bus.hlock[gidx];
         end
      end
   end

   assign bus.hgrant    = hgrant_q;
   assign bus.hmaster   = hmaster_q;
   assign bus.hmastlock = hmastlock_q;
endmodule

// File: tb/tb_ahb2_arbiter.sv
// Bench for ahb2_arbiter: one round-robin and one fixed-priority instance
// share the same stimulus and are compared against a behavioural model.
module tb_ahb2_arbiter;
   import ahb2_pkg::*;

   localparam int N   = 4;
   localparam int DEF = 0;

   logic         hclk     = 1'b0;
   logic         hreset_n = 1'b0;
   logic [N-1:0] hbusreq  = '0;
   logic [N-1:0] hlock    = '0;
   logic [1:0]   htrans   = 2'b00;
   logic [2:0]   hburst   = 3'b000;
   logic         hready   = 1'b1;
   logic [1:0]   hresp    = 2'b00;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state, index 0 = fixed priority, 1 = round-robin.
   int m_g[2], m_bl[2], m_rr[2], m_hm[2], m_hml[2];

   always #5 hclk = ~hclk;

   ahb2_arbiter_if #(.NUM_MASTERS(N)) bus_rr ();
   ahb2_arbiter_if #(.NUM_MASTERS(N)) bus_fp ();

   assign bus_rr.hbusreq = hbusreq;
   assign bus_rr.hlock   = hlock;
   assign bus_rr.htrans  = htrans;
   assign bus_rr.hburst  = hburst;
   assign bus_rr.hready  = hready;
   assign bus_rr.hresp   = hresp;
   assign bus_fp.hbusreq = hbusreq;
   assign bus_fp.hlock   = hlock;
   assign bus_fp.htrans  = htrans;
   assign bus_fp.hburst  = hburst;
   assign bus_fp.hready  = hready;
   assign bus_fp.hresp   = hresp;

   ahb2_arbiter #(
      .NUM_MASTERS    (N),
      .RR_MODE        (1'b1),
      .DEFAULT_MASTER (DEF)
   ) dut_rr (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .bus      (bus_rr)
   );

   ahb2_arbiter #(
      .NUM_MASTERS    (N),
      .RR_MODE        (1'b0),
      .DEFAULT_MASTER (DEF)
   ) dut_fp (
      .hclk     (hclk),
      .hreset_n (hreset_n),
      .bus      (bus_fp)
   );

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int beats_of(input logic [2:0] b);
      if (b < 3'd2) return 0;
      return 4 << ((int'(b) - 2) / 2);
   endfunction

   task automatic model_reset();
      for (int md = 0; md < 2; md++) begin
         m_g[md]   = DEF;
         m_bl[md]  = 0;
         m_rr[md]  = DEF;
         m_hm[md]  = DEF;
         m_hml[md] = 0;
      end
   endtask

   // One clock edge of the arbitration rules, using the inputs now applied.
   task automatic model_edge();
      for (int md = 0; md < 2; md++) begin
         int  bl_n, g_old, win, m;
         bit  found, hold;
         g_old = m_g[md];
         bl_n  = m_bl[md];
         if (hresp != 2'b00) bl_n = 0;
         else if (hready) begin
            if (htrans == 2'b10) bl_n = (beats_of(hburst) > 0) ? beats_of(hburst) - 1 : 0;
            else if (htrans == 2'b11 && bl_n > 0) bl_n = bl_n - 1;
            else if (htrans == 2'b00) bl_n = 0;
         end
         hold = (bl_n != 0) || (hlock[g_old] && hbusreq[g_old]);
         if (hready && !hold) begin
            win   = DEF;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               m = (md == 1) ? (m_rr[md] + 1 + k) % N : k;
               if (!found && hbusreq[m]) begin
                  found = 1'b1;
                  win   = m;
               end
            end
            m_g[md] = win;
            if (found) m_rr[md] = win;
         end
         if (hready) begin
            m_hm[md]  = g_old;
            m_hml[md] = int'(hlock[g_old]);
         end
         m_bl[md] = bl_n;
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, " fp.hgrant"},    int'(bus_fp.hgrant),    1 << m_g[0]);
      check_eq({tag, " fp.hmaster"},   int'(bus_fp.hmaster),   m_hm[0]);
      check_eq({tag, " fp.hmastlock"}, int'(bus_fp.hmastlock), m_hml[0]);
      check_eq({tag, " rr.hgrant"},    int'(bus_rr.hgrant),    1 << m_g[1]);
      check_eq({tag, " rr.hmaster"},   int'(bus_rr.hmaster),   m_hm[1]);
      check_eq({tag, " rr.hmastlock"}, int'(bus_rr.hmastlock), m_hml[1]);
   endtask

   task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lck,
                        input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic [1:0] rsp);
      hbusreq = req;
      hlock   = lck;
      htrans  = tr;
      hburst  = bu;
      hready  = rdy;
      hresp   = rsp;
   endtask

   task automatic cycle(input string tag);
      model_edge();
      @(posedge hclk);
      #1;
      check_outputs(tag);
   endtask

   // Asynchronous reset between edges; outputs must settle before any clock.
   task automatic async_reset(input string tag);
      #3;
      hreset_n = 1'b0;
      #1;
      model_reset();
      check_outputs({tag, " async"});
      check_eq({tag, " rr.hgrant const"}, int'(bus_rr.hgrant), 1);
      check_eq({tag, " fp.hgrant const"}, int'(bus_fp.hgrant), 1);
      @(posedge hclk);
      #1;
      check_outputs({tag, " held"});
      #2;
      hreset_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #12;
      check_outputs("reset");
      check_eq("reset rr.hgrant", int'(bus_rr.hgrant), 4'b0001);
      @(negedge hclk);
      hreset_n = 1'b1;

      // Parking with no requests.
      drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      for (int i = 0; i < 10; i++) cycle("park");
      check_eq("park rr.hgrant", int'(bus_rr.hgrant), 4'b0001);

      // All request, single transfers: RR rotates, fixed stays on 0.
      drive(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      for (int i = 0; i < 4; i++) begin
         cycle("rot");
         check_eq("rot rr.hgrant", int'(bus_rr.hgrant), 1 << ((i + 1) % N));
         check_eq("rot fp.hgrant", int'(bus_fp.hgrant), 4'b0001);
      end

      // INCR4 from master 2 with one wait state on beat 3.
      drive(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      cycle("b4 grant");
      drive(4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
      cycle("b4 nseq");
      check_eq("b4 held rr", int'(bus_rr.hgrant), 4'b0100);
      drive(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
      cycle("b4 seq1");
      drive(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b0, HRESP_OKAY);
      cycle("b4 wait");
      check_eq("b4 wait rr", int'(bus_rr.hgrant), 4'b0100);
      drive(4'b0110, 4'b0000, HTRANS_SEQ, HBURST_INCR4, 1'b1, HRESP_OKAY);
      cycle("b4 seq2");
      check_eq("b4 seq2 rr", int'(bus_rr.hgrant), 4'b0100);
      cycle("b4 seq3");
      check_eq("b4 handover rr", int'(bus_rr.hgrant), 4'b0010);
      check_eq("b4 handover fp", int'(bus_fp.hgrant), 4'b0010);

      // Locked singles from master 3 while master 0 requests.
      drive(4'b1000, 4'b1000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      cycle("lk grant");
      drive(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      for (int i = 0; i < 3; i++) begin
         cycle("lk xfer");
         check_eq("lk rr.hgrant", int'(bus_rr.hgrant), 4'b1000);
         check_eq("lk rr.hmastlock", int'(bus_rr.hmastlock), 1);
      end
      drive(4'b1001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      cycle("lk drop");
      check_eq("lk drop rr.hgrant", int'(bus_rr.hgrant), 4'b0001);

      // INCR8 from master 1 terminated by an ERROR on beat 3.
      drive(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      cycle("er grant");
      drive(4'b0011, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1, HRESP_OKAY);
      cycle("er nseq");
      drive(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b1, HRESP_OKAY);
      cycle("er seq1");
      cycle("er seq2");
      drive(4'b0011, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b0, HRESP_ERROR);
      cycle("er resp1");
      check_eq("er resp1 rr", int'(bus_rr.hgrant), 4'b0010);
      drive(4'b0011, 4'b0000, HTRANS_IDLE, HBURST_INCR8, 1'b1, HRESP_ERROR);
      cycle("er resp2");
      check_eq("er regrant rr", int'(bus_rr.hgrant), 4'b0001);
      check_eq("er regrant fp", int'(bus_fp.hgrant), 4'b0001);

      // Fixed priority with 1010, then reset in the middle of a burst.
      drive(4'b1010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      for (int i = 0; i < 4; i++) begin
         cycle("fp");
         check_eq("fp win1", int'(bus_fp.hgrant), 4'b0010);
      end
      drive(4'b1010, 4'b0000, HTRANS_NONSEQ, HBURST_INCR16, 1'b1, HRESP_OKAY);
      cycle("rs nseq");
      drive(4'b1010, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b1, HRESP_OKAY);
      cycle("rs seq");
      async_reset("rs");
      drive(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1, HRESP_OKAY);
      cycle("rs after");

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] rq;
         logic [1:0]   tr, rsp;
         int           sel;
         rq  = N'($urandom);
         sel = int'($urandom_range(0, 9));
         tr  = (sel < 2) ? HTRANS_IDLE : (sel < 3) ? HTRANS_BUSY :
               (sel < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
         rsp = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : HRESP_OKAY;
         drive(rq, rq & N'($urandom) & N'($urandom), tr, 3'($urandom),
               ($urandom_range(0, 4) != 0), rsp);
         cycle("rand");
         if ($urandom_range(0, 299) == 0) async_reset("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
